// File: rtl/fibonacci_checker.sv
// Receive-side monitor that locks onto a Fibonacci stream and checks each term.
// Ports: clk, reset (sync, active-high), in_valid, f_in[W] in; locked, match,
//   mismatch, period_done, seq_index[5], err_count[8], period_count[8] out.
module fibonacci_checker #(
  parameter int W       = 14,
  parameter int FIB_MAX = 21
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] f_in,
  output logic         locked,
  output logic         match,
  output logic         mismatch,
  output logic         period_done,
  output logic [4:0]   seq_index,
  output logic [7:0]   err_count,
  output logic [7:0]   period_count
);

  typedef enum logic {
    S_SEARCH,
    S_LOCKED
  } state_t;

  localparam logic [W-1:0] LP_MAX  = W'(FIB_MAX);
  localparam logic [W-1:0] LP_ZERO = '0;
  localparam logic [W-1:0] LP_ONE  = W'(1);

  state_t       r_state;
  logic [W-1:0] r_en;
  logic [W-1:0] r_en1;
  logic         r_match;
  logic         r_mismatch;
  logic         r_period_done;
  logic [4:0]   r_seq_index;
  logic [7:0]   r_err_count;
  logic [7:0]   r_period_count;

  logic         w_is_zero;
  logic         w_hit;
  logic         w_wrap;
  logic [4:0]   w_seq_next;
  logic [7:0]   w_err_next;

  assign w_is_zero = (f_in == LP_ZERO);
  assign w_hit     = (f_in == r_en);
  // Successor beyond the limit: this term closes a period.
  assign w_wrap    = (r_en1 > LP_MAX);
  // Index follows the matched term, so a matched 0 always reads back as 0.
  assign w_seq_next = w_is_zero ? 5'd0 : r_seq_index + 5'd1;
  assign w_err_next = (r_err_count == 8'hFF) ? r_err_count
                                             : r_err_count + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_SEARCH;
      r_en           <= LP_ZERO;
      r_en1          <= LP_ONE;
      r_match        <= 1'b0;
      r_mismatch     <= 1'b0;
      r_period_done  <= 1'b0;
      r_seq_index    <= 5'd0;
      r_err_count    <= 8'd0;
      r_period_count <= 8'd0;
    end else begin
      r_match       <= 1'b0;
      r_mismatch    <= 1'b0;
      r_period_done <= 1'b0;
      if (in_valid) begin
        unique case (r_state)
          S_SEARCH: begin
            if (w_is_zero) begin
              r_state     <= S_LOCKED;
              r_match     <= 1'b1;
              r_seq_index <= 5'd0;
              r_en        <= LP_ONE;
              r_en1       <= LP_ONE;
            end
          end
          S_LOCKED: begin
            if (w_hit) begin
              r_match     <= 1'b1;
              r_seq_index <= w_seq_next;
              if (w_wrap) begin
                r_en           <= LP_ZERO;
                r_en1          <= LP_ONE;
                r_period_done  <= 1'b1;
                r_period_count <= r_period_count + 8'd1;
              end else begin
                r_en  <= r_en1;
                r_en1 <= r_en + r_en1;
              end
            end else begin
              r_mismatch  <= 1'b1;
              r_err_count <= w_err_next;
              if (w_is_zero) begin
                // A stray 0 is taken as a fresh period start.
                r_seq_index <= 5'd0;
                r_en        <= LP_ONE;
                r_en1       <= LP_ONE;
              end else begin
                r_state <= S_SEARCH;
                r_en    <= LP_ZERO;
                r_en1   <= LP_ONE;
              end
            end
          end
          default: begin
            r_state <= S_SEARCH;
            r_en    <= LP_ZERO;
            r_en1   <= LP_ONE;
          end
        endcase
      end
    end
  end

  assign locked       = (r_state == S_LOCKED);
  assign match        = r_match;
  assign mismatch     = r_mismatch;
  assign period_done  = r_period_done;
  assign seq_index    = r_seq_index;
  assign err_count    = r_err_count;
  assign period_count = r_period_count;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed bench for fibonacci_checker.
// Drives on negedge, samples #1 after posedge.
module tb_fibonacci_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [13:0] f_in;
  logic        locked;
  logic        match;
  logic        mismatch;
  logic        period_done;
  logic [4:0]  seq_index;
  logic [7:0]  err_count;
  logic [7:0]  period_count;

  int total = 0;
  int bad   = 0;

  fibonacci_checker #(.W(14), .FIB_MAX(21)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .f_in         (f_in),
    .locked       (locked),
    .match        (match),
    .mismatch     (mismatch),
    .period_done  (period_done),
    .seq_index    (seq_index),
    .err_count    (err_count),
    .period_count (period_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic v, input int d);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = v;
    f_in     = 14'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    f_in     = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pulses(input string tag, input int m, input int mm,
                            input int pd);
    chk({tag, ".match"}, int'(match), m);
    chk({tag, ".mismatch"}, int'(mismatch), mm);
    chk({tag, ".pdone"}, int'(period_done), pd);
  endtask

  int vals [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 0};
  int seqs [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0};
  int fib9 [9]  = '{0, 1, 1, 2, 3, 5, 8, 13, 21};
  int n_mm;
  int n_pd;
  int n_m;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    f_in     = '0;

    // reset state
    do_reset();
    do_reset();
    chk("rst.locked", int'(locked), 0);
    chk_pulses("rst", 0, 0, 0);
    chk("rst.seq", int'(seq_index), 0);
    chk("rst.err", int'(err_count), 0);
    chk("rst.per", int'(period_count), 0);

    // one full period plus the restart 0
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vals[i]);
      chk($sformatf("str%0d.locked", i), int'(locked), 1);
      chk_pulses($sformatf("str%0d", i), 1, 0, (i == 8) ? 1 : 0);
      chk($sformatf("str%0d.seq", i), int'(seq_index), seqs[i]);
    end
    chk("str.per", int'(period_count), 1);
    chk("str.err", int'(err_count), 0);
    step(1'b0, 0);
    chk_pulses("str.idle", 0, 0, 0);

    // junk before lock is ignored
    do_reset();
    step(1'b1, 5);
    chk_pulses("srch5", 0, 0, 0);
    chk("srch5.locked", int'(locked), 0);
    step(1'b1, 7);
    chk_pulses("srch7", 0, 0, 0);
    step(1'b1, 0);
    chk_pulses("srch0", 1, 0, 0);
    chk("srch0.locked", int'(locked), 1);
    step(1'b1, 1);
    chk_pulses("srch1", 1, 0, 0);
    chk("srch.err", int'(err_count), 0);

    // nonzero mismatch drops lock
    do_reset();
    step(1'b1, 0);
    step(1'b1, 1);
    step(1'b1, 1);
    step(1'b1, 4);
    chk_pulses("mm4", 0, 1, 0);
    chk("mm4.locked", int'(locked), 0);
    chk("mm4.err", int'(err_count), 1);
    step(1'b1, 1);
    chk_pulses("mm4.nx1", 0, 0, 0);
    chk("mm4.nx1.locked", int'(locked), 0);
    step(1'b1, 0);
    chk("mm4.re0.locked", int'(locked), 1);
    chk("mm4.re0.seq", int'(seq_index), 0);
    chk("mm4.re0.err", int'(err_count), 1);

    // zero mismatch re-acquires in place
    do_reset();
    step(1'b1, 0);
    step(1'b1, 1);
    step(1'b1, 1);
    step(1'b1, 2);
    chk("z.pre.seq", int'(seq_index), 3);
    step(1'b1, 0);
    chk_pulses("z0", 0, 1, 0);
    chk("z0.locked", int'(locked), 1);
    chk("z0.seq", int'(seq_index), 0);
    chk("z0.err", int'(err_count), 1);
    step(1'b1, 1);
    chk_pulses("z1", 1, 0, 0);
    chk("z1.seq", int'(seq_index), 1);

    // invalid cycles with garbage hold everything
    do_reset();
    step(1'b1, 0);
    chk_pulses("gv0", 1, 0, 0);
    step(1'b0, 99);
    chk_pulses("gi1", 0, 0, 0);
    step(1'b0, 1);
    chk_pulses("gi2", 0, 0, 0);
    chk("gi2.seq", int'(seq_index), 0);
    step(1'b1, 1);
    chk_pulses("gv1", 1, 0, 0);
    step(1'b0, 0);
    chk_pulses("gi3", 0, 0, 0);
    chk("gi3.locked", int'(locked), 1);
    step(1'b1, 1);
    chk_pulses("gv2", 1, 0, 0);
    chk("g.seq", int'(seq_index), 2);
    chk("g.err", int'(err_count), 0);

    // error counter saturation
    do_reset();
    n_mm = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 0);
      step(1'b1, 5);
      if (mismatch) n_mm++;
      if (i == 253) chk("sat.254", int'(err_count), 254);
    end
    chk("sat.pulses", n_mm, 300);
    chk("sat.err", int'(err_count), 255);
    chk("sat.locked", int'(locked), 0);

    // period counter wrap
    do_reset();
    n_pd = 0;
    n_m  = 0;
    for (int p = 0; p < 257; p++) begin
      for (int k = 0; k < 9; k++) begin
        step(1'b1, fib9[k]);
        if (period_done) n_pd++;
        if (match) n_m++;
      end
      if (p == 255) chk("per.256", int'(period_count), 0);
    end
    chk("per.pulses", n_pd, 257);
    chk("per.matches", n_m, 257 * 9);
    chk("per.count", int'(period_count), 1);
    chk("per.err", int'(err_count), 0);

    // reset mid-stream
    step(1'b1, 0);
    step(1'b1, 1);
    step(1'b1, 1);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    f_in     = 14'd2;
    @(posedge clk);
    #1;
    chk("mid.locked", int'(locked), 0);
    chk_pulses("mid", 0, 0, 0);
    chk("mid.seq", int'(seq_index), 0);
    chk("mid.err", int'(err_count), 0);
    chk("mid.per", int'(period_count), 0);
    step(1'b1, 1);
    chk("mid.nx.locked", int'(locked), 0);
    chk_pulses("mid.nx", 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
